// File: rtl/div_pkg.sv
// Shared types and helpers for the multi-cycle integer divider.
package div_pkg;
    localparam int DIV_DEFAULT_WIDTH = 64;
    // Widest operand abs_val can handle; div_unit instances must not exceed it.
    localparam int DIV_MAX_WIDTH = 256;

    typedef enum logic [2:0] {
        IDLE,
        BUSY,
        FIXUP,
        SPECIAL,
        DONE
    } div_state_e;

    // Magnitude of a w-bit value held zero-extended in x; signed MIN maps to 2**(w-1).
    function automatic logic [DIV_MAX_WIDTH-1:0] abs_val(
        input logic [DIV_MAX_WIDTH-1:0] x,
        input int unsigned              w,
        input logic                     is_signed
    );
        logic [DIV_MAX_WIDTH-1:0] mask;
        mask = ~({DIV_MAX_WIDTH{1'b1}} << w);
        if (is_signed && (|((x >> (w - 1)) & DIV_MAX_WIDTH'(1))))
            return (~x + DIV_MAX_WIDTH'(1)) & mask;
        return x;
    endfunction
endpackage

// File: rtl/div_step.sv
// One restoring radix-2 iteration: shift in the next dividend bit, subtract when the divisor fits.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);
    logic [WIDTH+1:0] trial;
    logic [WIDTH:0]   diff;
    logic             fits;

    // quo_i doubles as the dividend shift register; its MSB is the next bit to bring down.
    always_comb begin
        trial = {rem_i, quo_i[WIDTH-1]};
        fits  = trial >= {2'b00, dvs_i};
        diff  = trial[WIDTH:0] - {1'b0, dvs_i};
        rem_o = fits ? diff : trial[WIDTH:0];
        quo_o = {quo_i[WIDTH-2:0], fits};
    end
endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider returning quotient and remainder with a ROB tag,
// RISC-V divide-by-zero/overflow results and flush abort.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_DEFAULT_WIDTH,
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    output logic             ready,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             valid_out,
    input  logic             yumi_in,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [TAG_W-1:0] tag_out
);
    localparam int               CNT_W   = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] quo_res_q;
    logic [WIDTH-1:0] rem_res_q;
    logic [TAG_W-1:0] tag_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             div0_q;

    logic             is_div0;
    logic             is_ovf;
    logic             is_special;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;

    assign is_div0    = (divisor == '0);
    assign is_ovf     = signed_div && (dividend == MIN_VAL) && (divisor == '1);
    assign is_special = is_div0 || is_ovf;
    assign dvd_mag    = WIDTH'(abs_val(DIV_MAX_WIDTH'(dividend), WIDTH, signed_div));
    assign dvs_mag    = WIDTH'(abs_val(DIV_MAX_WIDTH'(divisor), WIDTH, signed_div));

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i(rem_q),
        .quo_i(quo_q),
        .dvs_i(dvs_q),
        .rem_o(step_rem),
        .quo_o(step_quo)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (valid_in) state_d = is_special ? SPECIAL : BUSY;
                BUSY:    if (cnt_q == '0) state_d = FIXUP;
                FIXUP:   state_d = DONE;
                SPECIAL: state_d = DONE;
                DONE:    if (yumi_in) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        ready     = (state_q == IDLE) && !reset;
        valid_out = (state_q == DONE);
    end

    // Special operations park the raw dividend in quo_q; SPECIAL derives both results from it.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            quo_res_q <= '0;
            rem_res_q <= '0;
            tag_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
        end else if (!flush) begin
            case (state_q)
                IDLE: begin
                    if (valid_in) begin
                        tag_q     <= tag_in;
                        cnt_q     <= CNT_W'(WIDTH - 1);
                        rem_q     <= '0;
                        quo_q     <= is_special ? dividend : dvd_mag;
                        dvs_q     <= dvs_mag;
                        div0_q    <= is_div0;
                        neg_quo_q <= signed_div && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_rem_q <= signed_div && dividend[WIDTH-1];
                    end
                end
                BUSY: begin
                    rem_q <= step_rem;
                    quo_q <= step_quo;
                    if (cnt_q != '0)
                        cnt_q <= cnt_q - CNT_W'(1);
                end
                FIXUP: begin
                    quo_res_q <= neg_quo_q ? -quo_q : quo_q;
                    rem_res_q <= neg_rem_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                end
                SPECIAL: begin
                    quo_res_q <= div0_q ? '1 : quo_q;
                    rem_res_q <= div0_q ? quo_q : '0;
                end
                default: ;
            endcase
        end
    end

    assign quotient  = quo_res_q;
    assign remainder = rem_res_q;
    assign tag_out   = tag_q;
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: vector table, hand sequences and randomized ops vs a reference model.
module tb_div_unit;
    localparam int TW = 6;

    logic clk;
    logic reset;

    logic          a_valid_in, a_ready, a_signed, a_flush, a_valid_out, a_yumi;
    logic [63:0]   a_dividend, a_divisor, a_quotient, a_remainder;
    logic [TW-1:0] a_tag_in, a_tag_out;

    logic          b_valid_in, b_ready, b_signed, b_flush, b_valid_out, b_yumi;
    logic [31:0]   b_dividend, b_divisor, b_quotient, b_remainder;
    logic [TW-1:0] b_tag_in, b_tag_out;

    div_unit #(.WIDTH(64), .TAG_W(TW)) dut64 (
        .clk(clk), .reset(reset), .valid_in(a_valid_in), .ready(a_ready),
        .signed_div(a_signed), .dividend(a_dividend), .divisor(a_divisor),
        .tag_in(a_tag_in), .flush(a_flush), .valid_out(a_valid_out),
        .yumi_in(a_yumi), .quotient(a_quotient), .remainder(a_remainder),
        .tag_out(a_tag_out)
    );

    div_unit #(.WIDTH(32), .TAG_W(TW)) dut32 (
        .clk(clk), .reset(reset), .valid_in(b_valid_in), .ready(b_ready),
        .signed_div(b_signed), .dividend(b_dividend), .divisor(b_divisor),
        .tag_in(b_tag_in), .flush(b_flush), .valid_out(b_valid_out),
        .yumi_in(b_yumi), .quotient(b_quotient), .remainder(b_remainder),
        .tag_out(b_tag_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Selected-instance view so tasks work for either width.
    logic          sel_b;
    logic          m_ready, m_valid;
    logic [63:0]   m_quo, m_rem;
    logic [TW-1:0] m_tag;
    assign m_ready = sel_b ? b_ready : a_ready;
    assign m_valid = sel_b ? b_valid_out : a_valid_out;
    assign m_quo   = sel_b ? {32'h0, b_quotient} : a_quotient;
    assign m_rem   = sel_b ? {32'h0, b_remainder} : a_remainder;
    assign m_tag   = sel_b ? b_tag_out : a_tag_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          w32;
        logic          sgn;
        logic [63:0]   a;
        logic [63:0]   b;
        logic [TW-1:0] tag;
        logic [63:0]   q;
        logic [63:0]   r;
        int            lat;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Spec-level reference: plain integer division with RISC-V special cases.
    function automatic void ref_div(input logic w32, input logic sgn, input logic [63:0] a_in,
                                    input logic [63:0] b_in, output logic [63:0] q,
                                    output logic [63:0] r, output int lat);
        int          w;
        logic [63:0] mask, a, b;
        longint      sa, sb, smin;
        w    = w32 ? 32 : 64;
        mask = w32 ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
        a    = a_in & mask;
        b    = b_in & mask;
        sa   = longint'(a << (64 - w)) >>> (64 - w);
        sb   = longint'(b << (64 - w)) >>> (64 - w);
        smin = -(longint'(1) << (w - 1));
        lat  = w + 2;
        if (b == 64'd0) begin
            q = mask; r = a; lat = 2;
        end else if (!sgn) begin
            q = a / b; r = a % b;
        end else if (sa == smin && sb == -1) begin
            q = a; r = 64'd0; lat = 2;
        end else begin
            q = 64'(sa / sb) & mask;
            r = 64'(sa % sb) & mask;
        end
    endfunction

    task automatic drive(input logic w32, input logic sgn, input logic [63:0] a,
                         input logic [63:0] b, input logic [TW-1:0] t, input logic v);
        sel_b = w32;
        if (w32) begin
            b_valid_in = v; b_signed = sgn; b_dividend = a[31:0]; b_divisor = b[31:0]; b_tag_in = t;
        end else begin
            a_valid_in = v; a_signed = sgn; a_dividend = a; a_divisor = b; a_tag_in = t;
        end
    endtask

    task automatic set_yumi(input logic v);
        if (sel_b) b_yumi = v;
        else a_yumi = v;
    endtask

    // Returns #1 after the accept edge.
    task automatic start_op(input logic w32, input logic sgn, input logic [63:0] a,
                            input logic [63:0] b, input logic [TW-1:0] t, input string name);
        int n;
        n = 0;
        @(negedge clk);
        sel_b = w32;
        while (!m_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, " ready_wait"}, 64'(n < 200), 64'd1);
        drive(w32, sgn, a, b, t, 1'b1);
        @(posedge clk); #1;
        drive(w32, sgn, a, b, t, 1'b0);
    endtask

    // lat counts rising edges with the accept edge as edge 1.
    task automatic wait_valid(input int start, output int lat);
        lat = start;
        while (!m_valid && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic take();
        @(negedge clk); set_yumi(1'b1);
        @(posedge clk); #1; set_yumi(1'b0);
    endtask

    task automatic run_and_check(input logic w32, input logic sgn, input logic [63:0] a,
                                 input logic [63:0] b, input logic [TW-1:0] t,
                                 input logic [63:0] eq, input logic [63:0] er,
                                 input int elat, input string name);
        int lat;
        start_op(w32, sgn, a, b, t, name);
        wait_valid(1, lat);
        $display("op %s: w32=%0d sgn=%0d a=%h b=%h tag=%h -> q=%h r=%h tag=%h lat=%0d",
                 name, w32, sgn, a, b, t, m_quo, m_rem, m_tag, lat);
        check({name, " lat"}, 64'(lat), 64'(elat));
        check({name, " quo"}, m_quo, eq);
        check({name, " rem"}, m_rem, er);
        check({name, " tag"}, 64'(m_tag), 64'(t));
        take();
        check({name, " ready_after_yumi"}, 64'(m_ready), 64'd1);
    endtask

    task automatic watch_no_valid(input string name);
        int seen;
        seen = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (a_valid_out) seen++;
        end
        check({name, " no_valid_out"}, 64'(seen), 64'd0);
    endtask

    logic          r_w32, r_sgn;
    logic [63:0]   r_a, r_b, r_q, r_r;
    logic [TW-1:0] r_tag;
    int            r_lat, lat;

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 64'd100, 64'd7, 6'h2A, 64'd14, 64'd2, 66};
        vecs[1]  = '{1'b0, 1'b1, -64'd100, 64'd7, 6'h01, -64'd14, -64'd2, 66};
        vecs[2]  = '{1'b0, 1'b1, 64'd100, -64'd7, 6'h02, -64'd14, 64'd2, 66};
        vecs[3]  = '{1'b0, 1'b1, -64'd100, -64'd7, 6'h03, 64'd14, -64'd2, 66};
        vecs[4]  = '{1'b0, 1'b0, 64'd5, 64'd0, 6'h04, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 2};
        vecs[5]  = '{1'b0, 1'b1, 64'h8000_0000_0000_0000, -64'd1, 6'h05,
                     64'h8000_0000_0000_0000, 64'd0, 2};
        vecs[6]  = '{1'b0, 1'b1, -64'd5, 64'd0, 6'h06, 64'hFFFF_FFFF_FFFF_FFFF, -64'd5, 2};
        vecs[7]  = '{1'b0, 1'b0, 64'd3, 64'd100, 6'h07, 64'd0, 64'd3, 66};
        vecs[8]  = '{1'b1, 1'b0, 64'hFFFF_FFFF, 64'h10, 6'h08, 64'h0FFF_FFFF, 64'hF, 34};
        vecs[9]  = '{1'b1, 1'b1, 64'hFFFF_FFFF, 64'h10, 6'h09, 64'd0, 64'hFFFF_FFFF, 34};
        vecs[10] = '{1'b1, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 6'h0A, 64'h8000_0000, 64'd0, 2};
        vecs[11] = '{1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'h3F,
                     64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 66};

        reset = 1'b1; sel_b = 1'b0;
        a_valid_in = 0; a_signed = 0; a_dividend = 0; a_divisor = 0; a_tag_in = 0; a_flush = 0; a_yumi = 0;
        b_valid_in = 0; b_signed = 0; b_dividend = 0; b_divisor = 0; b_tag_in = 0; b_flush = 0; b_yumi = 0;

        repeat (3) @(posedge clk);
        #1;
        check("reset ready", 64'(a_ready), 64'd0);
        check("reset ready32", 64'(b_ready), 64'd0);
        check("reset valid_out", 64'(a_valid_out), 64'd0);
        check("reset quotient", a_quotient, 64'd0);
        check("reset remainder", a_remainder, 64'd0);
        check("reset tag_out", 64'(a_tag_out), 64'd0);
        @(negedge clk); reset = 1'b0;
        #1;
        check("post_reset ready", 64'(a_ready), 64'd1);

        for (int i = 0; i < 12; i++)
            run_and_check(vecs[i].w32, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].tag,
                          vecs[i].q, vecs[i].r, vecs[i].lat, $sformatf("vec%0d", i));

        // Backpressure, plus yumi_in and valid_in while busy must be ignored.
        start_op(1'b0, 1'b0, 64'd1000, 64'd10, 6'h11, "bp");
        @(negedge clk);
        a_yumi = 1'b1;
        drive(1'b0, 1'b0, 64'd77, 64'd7, 6'h22, 1'b1);
        @(posedge clk); #1;
        a_yumi = 1'b0;
        drive(1'b0, 1'b0, 64'd77, 64'd7, 6'h22, 1'b0);
        check("bp busy_ready", 64'(a_ready), 64'd0);
        wait_valid(2, lat);
        check("bp lat", 64'(lat), 64'd66);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            $display("bp hold %0d: valid=%0d ready=%0d q=%h r=%h tag=%h",
                     i, a_valid_out, a_ready, a_quotient, a_remainder, a_tag_out);
            check($sformatf("bp hold%0d quo", i), a_quotient, 64'd100);
            check($sformatf("bp hold%0d ready", i), 64'(a_ready), 64'd0);
        end
        check("bp valid", 64'(a_valid_out), 64'd1);
        check("bp rem", a_remainder, 64'd0);
        check("bp tag", 64'(a_tag_out), 64'h11);
        take();
        check("bp ready_after_yumi", 64'(a_ready), 64'd1);
        check("bp valid_after_yumi", 64'(a_valid_out), 64'd0);

        // Flush ten cycles into BUSY.
        start_op(1'b0, 1'b0, 64'd1000, 64'd3, 6'h12, "fl");
        repeat (10) @(posedge clk);
        @(negedge clk); a_flush = 1'b1;
        @(posedge clk); #1; a_flush = 1'b0;
        $display("flush: ready=%0d valid=%0d", a_ready, a_valid_out);
        check("fl ready", 64'(a_ready), 64'd1);
        check("fl valid", 64'(a_valid_out), 64'd0);
        watch_no_valid("fl");
        run_and_check(1'b0, 1'b0, 64'd9, 64'd3, 6'd5, 64'd3, 64'd0, 66, "post_flush");

        // Flush together with valid_in in IDLE: not accepted.
        @(negedge clk);
        drive(1'b0, 1'b0, 64'd50, 64'd5, 6'h13, 1'b1);
        a_flush = 1'b1;
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 64'd50, 64'd5, 6'h13, 1'b0);
        a_flush = 1'b0;
        $display("flush+valid_in: ready=%0d", a_ready);
        check("fl_idle ready", 64'(a_ready), 64'd1);

        // Reset mid-operation.
        start_op(1'b0, 1'b1, -64'd1000, 64'd3, 6'h14, "rst");
        repeat (5) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("rst_mid ready_low", 64'(a_ready), 64'd0);
        check("rst_mid quotient", a_quotient, 64'd0);
        @(negedge clk); reset = 1'b0;
        #1;
        $display("reset mid-op: ready=%0d valid=%0d", a_ready, a_valid_out);
        check("rst_mid ready", 64'(a_ready), 64'd1);
        watch_no_valid("rst_mid");

        // Randomized ops against the reference model.
        for (int i = 0; i < 60; i++) begin
            r_w32 = 1'($urandom_range(0, 1));
            r_sgn = 1'($urandom_range(0, 1));
            r_tag = TW'($urandom);
            r_a   = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0:       r_b = 64'd0;
                1:       r_b = 64'hFFFF_FFFF_FFFF_FFFF;
                2:       r_b = 64'($urandom_range(1, 20));
                3:       r_b = 64'($urandom_range(1, 65535));
                default: r_b = {$urandom, $urandom};
            endcase
            if ($urandom_range(0, 5) == 0)
                r_a = r_w32 ? 64'h8000_0000 : 64'h8000_0000_0000_0000;
            if ($urandom_range(0, 4) == 0)
                r_a = 64'($urandom_range(0, 100));
            if (r_w32) begin
                r_a = r_a & 64'hFFFF_FFFF;
                r_b = r_b & 64'hFFFF_FFFF;
            end
            ref_div(r_w32, r_sgn, r_a, r_b, r_q, r_r, r_lat);
            run_and_check(r_w32, r_sgn, r_a, r_b, r_tag, r_q, r_r, r_lat, $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
